// File: rtl/imem_boot_ctrl_pkg.sv
// Shared state encodings and default geometry for the instruction-memory boot sequencer.
// IMEM_BOOT_CSUM_EN adds the CSUM state; its encoding is reserved in every build.
package imem_boot_ctrl_pkg;

    localparam logic [2:0] ST_LOAD  = 3'd0;
    localparam logic [2:0] ST_CSUM  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam logic [31:0] BOOT_BASE_ADDR = 32'h0000_0000;
    localparam int          BOOT_MAX_BYTES = 1024;

endpackage

// File: rtl/imem_csum.sv
// Mod-256 image checksum accumulator; is_zero looks one byte ahead (acc + din).
// Instantiated by imem_boot_ctrl only when IMEM_BOOT_CSUM_EN is defined.
module imem_csum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] din,
    output logic       is_zero
);

    logic [7:0] acc;
    logic [7:0] nxt;

    assign nxt     = acc + din;
    assign is_zero = (nxt == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 8'h00;
        end else if (clr) begin
            acc <= 8'h00;
        end else if (add_en) begin
            acc <= nxt;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: streams loader bytes into the IMEM write port, then hands the port to fetch.
// Define IMEM_BOOT_CSUM_EN to require a trailing mod-256 checksum byte.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BOOT_BASE_ADDR,
    parameter int          MAX_BYTES = BOOT_MAX_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic [31:0] fetch_addr,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        cpu_stall,
    output logic        boot_done,
    output logic        boot_err
);

    localparam int             CW       = $clog2(MAX_BYTES) + 1;
    localparam logic [CW-1:0]  CNT_FULL = CW'(MAX_BYTES);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic          live;
    logic [CW-1:0] count;
    logic          we_q;
    logic [7:0]    wdata_q;
    logic [31:0]   waddr_q;

    logic in_load;
    logic in_csum;
    logic in_run;
    logic in_err;
    logic full;
    logic accept;
    logic do_write;

    assign in_load  = (state == ST_LOAD);
    assign in_csum  = (state == ST_CSUM);
    assign in_run   = (state == ST_RUN);
    assign in_err   = (state == ST_ERR);
    assign full     = (count == CNT_FULL);
    assign accept   = ld_valid & ld_ready;
    assign do_write = accept & in_load & ~full;

`ifdef IMEM_BOOT_CSUM_EN
    logic csum_ok;

    imem_csum u_csum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .add_en  (do_write | (accept & in_csum)),
        .din     (ld_data),
        .is_zero (csum_ok)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_LOAD: begin
                if (accept) begin
                    if (full) begin
                        state_nx = ST_ERR;
                    end else if (ld_last) begin
`ifdef IMEM_BOOT_CSUM_EN
                        state_nx = ST_CSUM;
`else
                        state_nx = ST_DRAIN;
`endif
                    end
                end
            end
            ST_CSUM: begin
`ifdef IMEM_BOOT_CSUM_EN
                if (accept) begin
                    state_nx = csum_ok ? ST_DRAIN : ST_ERR;
                end
`else
                state_nx = ST_ERR;
`endif
            end
            ST_DRAIN: state_nx = ST_RUN;
            ST_RUN:   state_nx = ST_RUN;
            ST_ERR:   state_nx = ST_ERR;
            default:  state_nx = ST_ERR;
        endcase
    end

    always_comb begin
        ld_ready  = 1'b0;
        cpu_stall = 1'b1;
        boot_done = 1'b0;
        boot_err  = 1'b0;
        mem_addr  = waddr_q;
        unique case (1'b1)
            in_load, in_csum: ld_ready = live;
            in_run: begin
                cpu_stall = 1'b0;
                boot_done = 1'b1;
                mem_addr  = fetch_addr;
            end
            in_err:  boot_err = 1'b1;
            default: ;
        endcase
    end

    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;

    // live holds ld_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            waddr_q <= 32'h0000_0000;
        end else begin
            we_q <= do_write;
            if (do_write) begin
                count   <= count + CW'(1);
                wdata_q <= ld_data;
                waddr_q <= BASE_ADDR + 32'(count);
            end
        end
    end

endmodule
